// File: rtl/comparator_pkg.sv
// Shared definitions for the 8-bit registered comparator.
// Holds the result encoding, its one-hot flag form and the fixed width.
package comparator_pkg;

   localparam int CMP_WIDTH = 8;

   typedef enum logic [1:0] {
      CMP_EQ = 2'b00,
      CMP_GT = 2'b01,
      CMP_LT = 2'b10
   } cmp_res_e;

   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } cmp_flags_t;

   function automatic cmp_flags_t cmp_to_flags(input cmp_res_e r);
      cmp_flags_t f;
      f = '0;
      case (r)
         CMP_GT:  f.gt = 1'b1;
         CMP_LT:  f.lt = 1'b1;
         default: f.eq = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/comparator_4b_slice.sv
// Combinational 4-bit magnitude compare with 74x85-style cascade.
// Ports: i_a/i_b operands, i_gt/i_lt/i_eq cascade in, o_gt/o_lt/o_eq one-hot out.
import comparator_pkg::*;

module comparator_4b_slice (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_gt,
   input  logic       i_lt,
   input  logic       i_eq,
   output logic       o_gt,
   output logic       o_lt,
   output logic       o_eq
);

   cmp_res_e   w_res;
   cmp_flags_t w_flags;
   logic       w_unused_eq;

   // Operands win when they differ; on a tie the cascade decides with
   // GT over LT, and anything else (including all-zero) resolves to EQ.
   always_comb begin
      w_res = CMP_EQ;
      if (i_a > i_b)
         w_res = CMP_GT;
      else if (i_a < i_b)
         w_res = CMP_LT;
      else if (i_gt)
         w_res = CMP_GT;
      else if (i_lt)
         w_res = CMP_LT;
   end

   assign w_flags = cmp_to_flags(w_res);
   assign o_gt    = w_flags.gt;
   assign o_lt    = w_flags.lt;
   assign o_eq    = w_flags.eq;

   // Equal-in only informs; the result is EQ whenever GT/LT are both clear.
   assign w_unused_eq = i_eq;

endmodule

// File: rtl/comparator_8b.sv
// Registered 8-bit magnitude comparator with cascade, one-cycle latency.
// Ports: clk, rst_n (async low), in_valid, A, B, GreaterIn/LessIn/EqualIn,
// signed_mode (only with COMPARATOR_8B_SIGNED_EN), out_valid, Greater/Less/Equal.
import comparator_pkg::*;

module comparator_8b (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [CMP_WIDTH-1:0] A,
   input  logic [CMP_WIDTH-1:0] B,
   input  logic                 GreaterIn,
   input  logic                 LessIn,
   input  logic                 EqualIn,
`ifdef COMPARATOR_8B_SIGNED_EN
   input  logic                 signed_mode,
`endif
   output logic                 out_valid,
   output logic                 Greater,
   output logic                 Less,
   output logic                 Equal
);

   logic       w_flip;
   logic [3:0] w_a_hi;
   logic [3:0] w_b_hi;
   logic       w_lo_gt;
   logic       w_lo_lt;
   logic       w_lo_eq;
   cmp_flags_t w_hi_flags;

   logic       r_valid;
   cmp_flags_t r_flags;

`ifdef COMPARATOR_8B_SIGNED_EN
   assign w_flip = signed_mode;
`else
   assign w_flip = 1'b0;
`endif

   // Flipping both sign bits maps two's-complement order onto unsigned order.
   assign w_a_hi = {A[7] ^ w_flip, A[6:4]};
   assign w_b_hi = {B[7] ^ w_flip, B[6:4]};

   comparator_4b_slice u_lo (
      .i_a  (A[3:0]),
      .i_b  (B[3:0]),
      .i_gt (GreaterIn),
      .i_lt (LessIn),
      .i_eq (EqualIn),
      .o_gt (w_lo_gt),
      .o_lt (w_lo_lt),
      .o_eq (w_lo_eq)
   );

   comparator_4b_slice u_hi (
      .i_a  (w_a_hi),
      .i_b  (w_b_hi),
      .i_gt (w_lo_gt),
      .i_lt (w_lo_lt),
      .i_eq (w_lo_eq),
      .o_gt (w_hi_flags.gt),
      .o_lt (w_hi_flags.lt),
      .o_eq (w_hi_flags.eq)
   );

   // Flags load only on a valid sample and hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_flags <= '0;
      end else begin
         r_valid <= in_valid;
         if (in_valid)
            r_flags <= w_hi_flags;
      end
   end

   assign out_valid = r_valid;
   assign Greater   = r_flags.gt;
   assign Less      = r_flags.lt;
   assign Equal     = r_flags.eq;

endmodule

// File: tb/tb_comparator_8b.sv
// Self-checking bench for comparator_8b.
// Vector table plus random traffic through a scoreboard, with reset/hold sequences.
module tb_comparator_8b;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       g;
      logic       l;
      logic       e;
      logic       sm;
      logic [2:0] exp;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic       gi;
   logic       li;
   logic       ei;
   logic       sm;
   logic       out_valid;
   logic       gt;
   logic       lt;
   logic       eq;

   int         n_vec;
   int         n_err;
   logic [2:0] sb[$];
   vec_t       tbl[$];

   comparator_8b dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (a),
      .B         (b),
      .GreaterIn (gi),
      .LessIn    (li),
      .EqualIn   (ei),
`ifdef COMPARATOR_8B_SIGNED_EN
      .signed_mode (sm),
`endif
      .out_valid (out_valid),
      .Greater   (gt),
      .Less      (lt),
      .Equal     (eq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [3:0] act,
                        input logic [3:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %b want %b (v,G,L,E)", nm, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb,
                               input logic vg, input logic vl,
                               input logic ve, input logic vs,
                               input logic [2:0] vx);
      vec_t v;
      v.a = va; v.b = vb; v.g = vg; v.l = vl;
      v.e = ve; v.sm = vs; v.exp = vx;
      return v;
   endfunction

   // Reference model: integer ordering, then cascade priority on a tie.
   function automatic logic [2:0] model(input logic [7:0] ma,
                                        input logic [7:0] mb,
                                        input logic mg, input logic ml,
                                        input logic ms);
      int ia;
      int ib;
      ia = ms ? int'($signed(ma)) : int'(ma);
      ib = ms ? int'($signed(mb)) : int'(mb);
      if (ia > ib) return 3'b100;
      if (ia < ib) return 3'b010;
      if (mg) return 3'b100;
      if (ml) return 3'b010;
      return 3'b001;
   endfunction

   task automatic apply(input vec_t v);
      @(negedge clk);
      a = v.a; b = v.b;
      gi = v.g; li = v.l; ei = v.e;
      sm = v.sm;
      in_valid = 1'b1;
      sb.push_back(v.exp);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out", {out_valid, gt, lt, eq}, 4'b0000);
         end else begin
            logic [2:0] x;
            x = sb.pop_front();
            check("scoreboard", {out_valid, gt, lt, eq}, {1'b1, x});
         end
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      in_valid = 1'b1;
      a = 8'hFF; b = 8'h01;
      gi = 1'b1; li = 1'b0; ei = 1'b0;
      sm = 1'b0;
      #2;
      check("reset_async", {out_valid, gt, lt, eq}, 4'b0000);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_held", {out_valid, gt, lt, eq}, 4'b0000);
      rst_n = 1'b1;
      @(negedge clk);
      check("no_sample_yet", {out_valid, gt, lt, eq}, 4'b0000);

      tbl.push_back(mk(8'h00, 8'h00, 0, 0, 1, 0, 3'b001));
      tbl.push_back(mk(8'h08, 8'h10, 0, 0, 1, 0, 3'b010));
      tbl.push_back(mk(8'h10, 8'h08, 0, 0, 1, 0, 3'b100));
      tbl.push_back(mk(8'h5A, 8'h5A, 1, 0, 0, 0, 3'b100));
      tbl.push_back(mk(8'h5A, 8'h5A, 0, 1, 0, 0, 3'b010));
      tbl.push_back(mk(8'h5A, 8'h5A, 1, 1, 0, 0, 3'b100));
      tbl.push_back(mk(8'h5A, 8'h5A, 0, 0, 0, 0, 3'b001));
      tbl.push_back(mk(8'hFF, 8'h01, 0, 0, 1, 0, 3'b100));
      tbl.push_back(mk(8'h80, 8'h7F, 0, 0, 1, 0, 3'b100));
      tbl.push_back(mk(8'h5A, 8'h5B, 1, 0, 0, 0, 3'b010));
      tbl.push_back(mk(8'hA5, 8'h5A, 0, 1, 0, 0, 3'b100));
      tbl.push_back(mk(8'hF0, 8'h0F, 0, 0, 1, 0, 3'b100));
      tbl.push_back(mk(8'h0F, 8'h0E, 0, 1, 0, 0, 3'b100));
      tbl.push_back(mk(8'h3C, 8'h3D, 0, 0, 1, 0, 3'b010));
`ifdef COMPARATOR_8B_SIGNED_EN
      tbl.push_back(mk(8'hFF, 8'h01, 0, 0, 1, 1, 3'b010));
      tbl.push_back(mk(8'h80, 8'h7F, 0, 0, 1, 1, 3'b010));
      tbl.push_back(mk(8'hFF, 8'hFE, 0, 0, 1, 1, 3'b100));
      tbl.push_back(mk(8'h00, 8'hFF, 0, 0, 1, 1, 3'b100));
      tbl.push_back(mk(8'h81, 8'h81, 0, 1, 0, 1, 3'b010));
`endif

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i]);
      idle();

      for (int i = 0; i < 60; i++) begin
         vec_t v;
         v.a  = 8'($urandom_range(0, 255));
         v.b  = (i % 4 == 0) ? v.a : 8'($urandom_range(0, 255));
         v.g  = 1'($urandom_range(0, 1));
         v.l  = 1'($urandom_range(0, 1));
         v.e  = ~(v.g | v.l);
`ifdef COMPARATOR_8B_SIGNED_EN
         v.sm = 1'($urandom_range(0, 1));
`else
         v.sm = 1'b0;
`endif
         v.exp = model(v.a, v.b, v.g, v.l, v.sm);
         apply(v);
         if (i % 7 == 3)
            idle();
      end
      idle();
      @(negedge clk);
      check("sb_drained", {1'b0, 3'(sb.size())}, 4'b0000);

      // Hold: result stays while in_valid is low and inputs change.
      apply(mk(8'hFF, 8'h01, 0, 0, 1, 0, 3'b100));
      @(negedge clk);
      in_valid = 1'b0;
      a = 8'h00; b = 8'hFF;
      @(negedge clk);
      check("hold_1", {out_valid, gt, lt, eq}, 4'b0100);
      @(negedge clk);
      check("hold_2", {out_valid, gt, lt, eq}, 4'b0100);

      // Mid-stream reset clears immediately, no result until new sample.
      @(negedge clk);
      a = 8'h01; b = 8'h02;
      gi = 1'b0; li = 1'b0; ei = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("pre_reset", {out_valid, gt, lt, eq}, 4'b1010);
      rst_n = 1'b0;
      #1;
      check("midreset", {out_valid, gt, lt, eq}, 4'b0000);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("post_reset", {out_valid, gt, lt, eq}, 4'b0000);
      apply(mk(8'h22, 8'h22, 0, 0, 1, 0, 3'b001));
      idle();
      @(negedge clk);
      check("post_reset_drain", {1'b0, 3'(sb.size())}, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/comparator_8b.md
# comparator_8b

Registered 8-bit magnitude comparator with cascade inputs, used wherever two byte-wide operands must be ordered and the result consumed one clock later. It produces one-hot Greater/Less/Equal flags and accepts cascade flags from a lower-significance stage, so several instances chain into wider comparisons. Inputs are sampled under a valid qualifier; results are held until the next valid sample.

## Interface
- No parameters; width is fixed at 8 bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  sample A, B and cascade inputs this cycle.
- A  input  8  operand A.
- B  input  8  operand B.
- GreaterIn  input  1  cascade: lower stage found A>B.
- LessIn  input  1  cascade: lower stage found A<B.
- EqualIn  input  1  cascade: lower stage found A==B. Tie to 1 on the least-significant stage; tie GreaterIn and LessIn to 0 there.
- signed_mode  input  1  present only with COMPARATOR_8B_SIGNED_EN; 1 selects two's-complement ordering.
- out_valid  output  1  result registers updated last cycle.
- Greater  output  1  registered A>B.
- Less  output  1  registered A<B.
- Equal  output  1  registered A==B.

## Operation
- If A != B, the operands decide the result: Greater=1 when A>B, Less=1 when A<B. Cascade inputs are ignored.
- If A == B, the cascade inputs decide the result, by priority:
  - GreaterIn=1 gives Greater.
  - Else LessIn=1 gives Less.
  - Else Equal. An all-zero cascade is treated as equal; EqualIn is then informational only.
- Outputs are strictly one-hot whenever out_valid=1.
- Unsigned compare by default. In signed mode, A[7] and B[7] are sign bits: a negative operand is less than a non-negative one.

## Timing
- Reset (rst_n low, asynchronous): Greater=0, Less=0, Equal=0, out_valid=0. All outputs stay 0 until the first valid sample.
- Latency is 1 cycle. Inputs sampled at edge N with in_valid=1 appear on the outputs after edge N, with out_valid=1 for that cycle.
- in_valid=0 at an edge: out_valid goes to 0; Greater/Less/Equal hold their last value.
- Back-to-back valid samples give one result per cycle; there is no backpressure.
- Reset asserted mid-stream clears everything immediately. The first post-reset result follows the first valid sample after rst_n rises.
- No combinational path from any input to any output.

## Configuration
- COMPARATOR_8B_SIGNED_EN:
  - Defined: the signed_mode port exists and selects signed or unsigned ordering per sample. signed_mode is sampled with in_valid.
  - Undefined: the port is absent and the compare is unsigned only.
- Cascade behaviour is identical in both builds.

## Structure
- Shared package comparator_pkg holds:
  - the result encoding (CMP_GT, CMP_LT, CMP_EQ as a 2-bit enum), with a conversion to one-hot flags;
  - the constant CMP_WIDTH=8.
- Natural sub-module: comparator_4b_slice, a combinational 4-bit compare with cascade in and out in 74x85 style.
  - Instantiate two slices: the low slice takes the external cascade inputs, the high slice takes the low slice's outputs.
  - Signed mode inverts the MSB of both operands before the high slice.
  - Top level adds the registers, valid tracking and reset.

## Test plan
- Reset: rst_n=0 with any inputs -> all outputs 0 and out_valid=0, asynchronously, before any clock edge.
- Equal case: A=0x00, B=0x00, cascade (G,L,E)=(0,0,1), in_valid=1 -> next cycle Equal=1, Greater=0, Less=0, out_valid=1.
- Unsigned less: A=0x08, B=0x10 -> Less=1. Swap operands -> Greater=1.
- Cascade passthrough, A=B=0x5A:
  - GreaterIn=1 -> Greater=1;
  - LessIn=1 -> Less=1;
  - GreaterIn=LessIn=1 -> Greater=1;
  - all cascade 0 -> Equal=1.
- Hold: valid A=0xFF, B=0x01, then in_valid=0 with A=0x00, B=0xFF -> Greater stays 1 and out_valid drops to 0.
- Signed build: signed_mode=1, A=0xFF, B=0x01 -> Less=1. The same operands with signed_mode=0 -> Greater=1.
